global_buffer_multiregion: RTL and testbench
============================================

// Module: global_buffer_multiregion
// PURPOSE
//  Next-gen row-stationary global buffer with separate weight, activation and output regions.
//  Decodes global_buffer_instruction_t commands and runs burst writes into any region or burst
//  reads from the activation region. Reads support backpressure. Sits between the host/DMA side
//  and the PE-array feeders.
// PARAMETERS
//  DATA_SIZE   8    bits per element
//  LANES       16   elements per word; word width W = LANES*DATA_SIZE
//  DEPTH       256  words per region (power of 2); AW = $clog2(DEPTH) (localparam)
// PORTS
//  clk              in   1       clock, rising edge
//  nrst             in   1       synchronous reset, active low
//  instr_i          in   4       global_buffer_instruction_t opcode
//  instr_len_i      in   AW+1    burst length in words (0..DEPTH)
//  instr_valid_i    in   1       instruction valid
//  instr_ready_o    out  1       instruction accepted when valid&ready
//  wr_data_i        in   W       write word
//  wr_en_i          in   1       write valid
//  wr_ready_o       out  1       write accepted when wr_en_i&wr_ready_o
//  rd_data_o        out  W       read word
//  rd_data_valid_o  out  1       read word valid
//  rd_ready_i       in   1       consumer ready; transfer on valid&ready
//  busy_o           out  1       high in any state other than IDLE
//  done_o           out  1       one-cycle pulse at burst completion
//  err_o            out  1       sticky error flag
// BEHAVIOUR
//  Reset, nrst=0 at posedge (also mid-burst):
//   - FSM->IDLE; all pointers, read pipeline, err_o and done_o cleared.
//   - Outputs then read: instr_ready_o=1, wr_ready_o=0, rd_data_o=0, rd_data_valid_o=0, busy_o=0.
//   - Memory contents are not cleared.
//  FSM states: IDLE, LOAD, READ, DONE. instr_ready_o = (state==IDLE).
//  Instructions are ignored outside IDLE (no queue). Actions on accept:
//   - I_NOP: no effect; stay IDLE; no done_o.
//   - I_POINTER_RESET: zero wp_w, wp_a, wp_o and rp_a next cycle; clear err_o; done_o next cycle.
//   - I_LOAD_WEIGHT / I_LOAD_ACTIVATION / I_LOAD_OUTPUT: latch region and len; go to LOAD.
//   - I_READ_ACTIVATION: latch len; go to READ.
//   - Any other opcode: treated as NOP and sets err_o.
//  LOAD:
//   - wr_ready_o=1.
//   - Each accepted word writes mem[region][wp] and increments wp mod DEPTH.
//   - wp wrapping DEPTH-1 -> 0 sets err_o.
//   - After len words -> DONE.
//  READ:
//   - Issue a synchronous read of mem_a[rp_a]; rp_a increments mod DEPTH per issue (wrap is silent).
//   - A 2-entry output buffer carries 1-cycle RAM latency: first rd_data_valid_o 2 cycles after accept.
//   - Sustains 1 word/cycle while rd_ready_i=1.
//   - rd_ready_i=0: rd_data_o/rd_data_valid_o hold stable; no word dropped or duplicated.
//   - Issue stops when the buffer is full or all len words have been issued.
//   - DONE after the last word's valid&ready handshake.
//  len=0 on any LOAD/READ: go straight to DONE; no memory access.
//  DONE: done_o=1 for exactly 1 cycle, then IDLE.
//  busy_o=1 in LOAD/READ/DONE.
//  Output region: write-only in this generation; each region has an independent write pointer.
// CONFIGURATION
//  GLOBAL_BUFFER_LANE_MASK_EN defined:
//   - Adds port wr_mask_i (in, LANES): lane i written only when wr_mask_i[i]=1; masked lanes keep old data.
//   - wp advances on every accepted word regardless of mask.
//  GLOBAL_BUFFER_LANE_MASK_EN undefined: port absent; all lanes written on every accepted word.
// TESTING
//  1. Reset: nrst=0 for 2 cycles -> instr_ready_o=1, busy_o=0, rd_data_valid_o=0, err_o=0.
//  2. Load activation len=4 (words 0xA0..0xA3 replicated), then READ_ACTIVATION len=4 with rd_ready_i=1:
//     first valid 2 cycles after accept, then 0xA0..0xA3 on consecutive cycles; done_o pulses once.
//  3. READ len=4 with rd_ready_i toggled 1,0,0,1,...: exact sequence 0xA0..0xA3, no drop/dup;
//     rd_data_o stable while stalled.
//  4. LOAD_WEIGHT len=DEPTH+1: err_o=1 after the DEPTH-th word; word 0 overwritten;
//     POINTER_RESET clears err_o and all pointers.
//  5. nrst=0 mid-READ after 2 of 8 words: IDLE next cycle, rd_data_valid_o=0;
//     new READ len=2 returns words 0,1.
//  6. len=0 LOAD and opcode 4'hF: LOAD gives done_o 1 cycle after accept; 4'hF sets err_o, no done_o.
//     With GLOBAL_BUFFER_LANE_MASK_EN, mask 16'h0001 updates lane 0 only.

Source files
------------

// File: rtl/global_buffer_multiregion.sv
// Row-stationary global buffer: weight/activation/output regions, burst load and activation read.
// Optional per-lane write mask via GLOBAL_BUFFER_LANE_MASK_EN (adds port wr_mask_i).
module global_buffer_multiregion #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned LANES     = 16,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [3:0]                     instr_i,
  input  logic [$clog2(DEPTH):0]         instr_len_i,
  input  logic                           instr_valid_i,
  output logic                           instr_ready_o,
  input  logic [LANES*DATA_SIZE-1:0]     wr_data_i,
  input  logic                           wr_en_i,
`ifdef GLOBAL_BUFFER_LANE_MASK_EN
  input  logic [LANES-1:0]               wr_mask_i,
`endif
  output logic                           wr_ready_o,
  output logic [LANES*DATA_SIZE-1:0]     rd_data_o,
  output logic                           rd_data_valid_o,
  input  logic                           rd_ready_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = LANES * DATA_SIZE;
  localparam logic [AW:0] LEN_ONE = 1;

  typedef enum logic [3:0] {
    I_NOP             = 4'h0,
    I_POINTER_RESET   = 4'h1,
    I_LOAD_WEIGHT     = 4'h2,
    I_LOAD_ACTIVATION = 4'h3,
    I_LOAD_OUTPUT     = 4'h4,
    I_READ_ACTIVATION = 4'h5
  } global_buffer_instruction_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DONE} state_t;
  typedef enum logic [1:0] {REG_W = 2'd0, REG_A = 2'd1, REG_O = 2'd2} region_t;

  state_t          r_state, w_state_nxt;
  region_t         r_region;
  logic [AW:0]     r_len;
  logic [AW:0]     r_to_recv;
  logic [AW-1:0]   r_wp_w, r_wp_a, r_wp_o, r_rp_a, w_wp;
  logic            r_err;
  logic            r_pend;
  logic [W-1:0]    r_rdata;
  logic [W-1:0]    r_buf [0:1];
  logic [1:0]      r_cnt;
  logic            r_head, r_tail;
  logic [2:0]      w_occ;
  logic            w_instr_fire, w_wr_fire, w_pop, w_issue;
  logic [AW+1:0]   w_waddr, w_raddr;
  logic [LANES-1:0] w_lane_en;

  // One array holds all three regions; region code selects the upper address bits.
  logic [W-1:0]    mem [0:3*DEPTH-1];

`ifdef GLOBAL_BUFFER_LANE_MASK_EN
  assign w_lane_en = wr_mask_i;
`else
  assign w_lane_en = '1;
`endif

  assign instr_ready_o   = (r_state == S_IDLE);
  assign wr_ready_o      = (r_state == S_LOAD);
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_DONE);
  assign err_o           = r_err;
  assign rd_data_valid_o = (r_cnt != 2'd0);
  assign rd_data_o       = rd_data_valid_o ? r_buf[r_head] : '0;

  assign w_instr_fire = instr_valid_i & instr_ready_o;
  assign w_wr_fire    = wr_en_i & wr_ready_o & nrst;
  assign w_pop        = rd_data_valid_o & rd_ready_i;
  // Occupancy after this edge; issuing now lands one cycle later, so keep it below 2.
  assign w_occ   = {1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
  assign w_issue = (r_state == S_READ) && (r_len != '0) && (w_occ < 3'd2);
  assign w_waddr = {r_region, w_wp};
  assign w_raddr = {REG_A, r_rp_a};

  always_comb begin
    case (r_region)
      REG_W:   w_wp = r_wp_w;
      REG_A:   w_wp = r_wp_a;
      default: w_wp = r_wp_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (instr_valid_i) begin
          case (instr_i)
            I_POINTER_RESET: w_state_nxt = S_DONE;
            I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_LOAD_OUTPUT:
              w_state_nxt = (instr_len_i == '0) ? S_DONE : S_LOAD;
            I_READ_ACTIVATION:
              w_state_nxt = (instr_len_i == '0) ? S_DONE : S_READ;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: if (wr_en_i && r_len == LEN_ONE) w_state_nxt = S_DONE;
      S_READ: if (w_pop && r_to_recv == LEN_ONE) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_region  <= REG_W;
      r_len     <= '0;
      r_to_recv <= '0;
      r_wp_w    <= '0;
      r_wp_a    <= '0;
      r_wp_o    <= '0;
      r_rp_a    <= '0;
      r_err     <= 1'b0;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
    end else begin
      r_pend <= w_issue;
      r_cnt  <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      if (r_pend) begin
        r_buf[r_tail] <= r_rdata;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head    <= ~r_head;
        r_to_recv <= r_to_recv - LEN_ONE;
      end
      if (w_issue) begin
        r_rp_a <= r_rp_a + 1'b1;
        r_len  <= r_len - LEN_ONE;
      end
      if (w_wr_fire) begin
        case (r_region)
          REG_W:   r_wp_w <= r_wp_w + 1'b1;
          REG_A:   r_wp_a <= r_wp_a + 1'b1;
          default: r_wp_o <= r_wp_o + 1'b1;
        endcase
        if (w_wp == '1) r_err <= 1'b1;
        r_len <= r_len - LEN_ONE;
      end
      if (w_instr_fire) begin
        case (instr_i)
          I_NOP: ;
          I_POINTER_RESET: begin
            r_wp_w <= '0;
            r_wp_a <= '0;
            r_wp_o <= '0;
            r_rp_a <= '0;
            r_err  <= 1'b0;
          end
          I_LOAD_WEIGHT:     begin r_region <= REG_W; r_len <= instr_len_i; end
          I_LOAD_ACTIVATION: begin r_region <= REG_A; r_len <= instr_len_i; end
          I_LOAD_OUTPUT:     begin r_region <= REG_O; r_len <= instr_len_i; end
          I_READ_ACTIVATION: begin r_len <= instr_len_i; r_to_recv <= instr_len_i; end
          default: r_err <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (w_lane_en[l])
          mem[w_waddr][l*DATA_SIZE +: DATA_SIZE] <= wr_data_i[l*DATA_SIZE +: DATA_SIZE];
      end
    end
    if (w_issue) r_rdata <= mem[w_raddr];
  end

endmodule

// File: tb/tb_global_buffer_multiregion.sv
// Scoreboard bench for global_buffer_multiregion: load/read bursts, backpressure, wrap, reset.
module tb_global_buffer_multiregion;
  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned LANES     = 16;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned W         = LANES * DATA_SIZE;

  localparam logic [3:0] OP_NOP = 4'h0, OP_PRST = 4'h1, OP_LW = 4'h2,
                         OP_LA = 4'h3, OP_LO = 4'h4, OP_RA = 4'h5, OP_BAD = 4'hF;

  logic             clk = 1'b0;
  logic             nrst;
  logic [3:0]       instr_i;
  logic [AW:0]      instr_len_i;
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [W-1:0]     wr_data_i;
  logic             wr_en_i;
  logic [LANES-1:0] wr_mask_i;
  logic             wr_ready_o;
  logic [W-1:0]     rd_data_o;
  logic             rd_data_valid_o;
  logic             rd_ready_i;
  logic             busy_o, done_o, err_o;

  global_buffer_multiregion #(.DATA_SIZE(DATA_SIZE), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .instr_i(instr_i), .instr_len_i(instr_len_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
`ifdef GLOBAL_BUFFER_LANE_MASK_EN
    .wr_mask_i(wr_mask_i),
`endif
    .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [W-1:0] model_a [DEPTH];
  int unsigned  model_wp [3];
  int unsigned  model_rp = 0;
  logic         model_err = 1'b0;
  logic [W-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {LANES{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_ptr_clear();
    model_wp[0] = 0; model_wp[1] = 0; model_wp[2] = 0;
    model_rp = 0;
    model_err = 1'b0;
  endtask

  task automatic send_instr(input logic [3:0] op, input int unsigned len);
    instr_i       = op;
    instr_len_i   = (AW+1)'(len);
    instr_valid_i = 1'b1;
    check_val("instr_ready", W'(instr_ready_o), W'(1));
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic load(input logic [3:0] op, input int unsigned len, input logic [7:0] base,
                      input logic [LANES-1:0] mask);
    int unsigned r;
    logic [W-1:0] d;
    r = int'(op) - 2;
    send_instr(op, len);
    if (len == 0) begin
      check_val("load0_done", W'(done_o), W'(1));
      tick();
      check_val("load0_done_end", W'(done_o), W'(0));
      return;
    end
    for (int unsigned i = 0; i < len; i++) begin
      d = rep(8'(base + i));
      wr_data_i = d;
      wr_mask_i = mask;
      wr_en_i   = 1'b1;
      check_val("wr_ready", W'(wr_ready_o), W'(1));
      tick();
      if (op == OP_LA)
        for (int unsigned l = 0; l < LANES; l++)
          if (mask[l]) model_a[model_wp[r]][l*DATA_SIZE +: DATA_SIZE] = d[l*DATA_SIZE +: DATA_SIZE];
      if (model_wp[r] == DEPTH-1) model_err = 1'b1;
      model_wp[r] = (model_wp[r] + 1) % DEPTH;
      check_val("load_err", W'(err_o), W'(model_err));
    end
    wr_en_i = 1'b0;
    check_val("load_done", W'(done_o), W'(1));
    tick();
    check_val("load_done_pulse", W'(done_o), W'(0));
  endtask

  // stall_mode=0: always ready; 1: ready pattern 1,0,0 repeating
  task automatic read(input int unsigned len, input bit stall_mode);
    int cyc, first;
    bit stalled_prev;
    logic [W-1:0] held, e;
    for (int unsigned i = 0; i < len; i++) begin
      exp_q.push_back(model_a[model_rp]);
      model_rp = (model_rp + 1) % DEPTH;
    end
    send_instr(OP_RA, len);
    cyc = 0; first = -1; stalled_prev = 0; held = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      rd_ready_i = stall_mode ? (cyc % 3 == 0) : 1'b1;
      if (stalled_prev) begin
        check_val("stall_valid", W'(rd_data_valid_o), W'(1));
        check_val("stall_hold", rd_data_o, held);
      end
      if (rd_data_valid_o) begin
        if (first < 0) first = cyc;
        if (rd_ready_i) begin
          e = exp_q.pop_front();
          check_val("rd_data", rd_data_o, e);
        end
      end
      stalled_prev = rd_data_valid_o && !rd_ready_i;
      held = rd_data_o;
      tick();
      cyc++;
    end
    rd_ready_i = 1'b0;
    check_val("rd_timeout", W'(exp_q.size()), W'(0));
    exp_q.delete();
    if (!stall_mode) begin
      check_val("rd_latency", W'(first), W'(2));
      check_val("rd_burst_cycles", W'(cyc), W'(first + int'(len)));
    end
    check_val("rd_done", W'(done_o), W'(1));
    tick();
    check_val("rd_done_pulse", W'(done_o), W'(0));
    check_val("rd_idle", W'(busy_o), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    nrst = 1'b0; instr_i = OP_NOP; instr_len_i = '0; instr_valid_i = 1'b0;
    wr_data_i = '0; wr_en_i = 1'b0; wr_mask_i = '1; rd_ready_i = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) model_a[i] = 'x;
    model_ptr_clear();
    tick(); tick();
    check_val("rst_instr_ready", W'(instr_ready_o), W'(1));
    check_val("rst_busy", W'(busy_o), W'(0));
    check_val("rst_rd_valid", W'(rd_data_valid_o), W'(0));
    check_val("rst_err", W'(err_o), W'(0));
    check_val("rst_wr_ready", W'(wr_ready_o), W'(0));
    check_val("rst_rd_data", rd_data_o, '0);
    nrst = 1'b1;
    tick();

    load(OP_LA, 4, 8'hA0, '1);
    read(4, 1'b0);

    send_instr(OP_PRST, 0);
    model_ptr_clear();
    check_val("prst_done", W'(done_o), W'(1));
    tick();
    check_val("prst_done_pulse", W'(done_o), W'(0));
    read(4, 1'b1);

    load(OP_LW, DEPTH + 1, 8'h00, '1);
    check_val("wrap_err", W'(err_o), W'(1));
    send_instr(OP_PRST, 0);
    model_ptr_clear();
    tick();
    check_val("prst_err_clr", W'(err_o), W'(0));

    load(OP_LA, 8, 8'hB0, '1);
    send_instr(OP_RA, 8);
    rd_ready_i = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      if (rd_data_valid_o) begin
        check_val("mid_rd_data", rd_data_o, model_a[n]);
        n++;
      end
      tick();
      cyc++;
    end
    check_val("mid_rd_timeout", W'(n), W'(2));
    nrst = 1'b0;
    rd_ready_i = 1'b0;
    tick();
    check_val("mid_rst_valid", W'(rd_data_valid_o), W'(0));
    check_val("mid_rst_busy", W'(busy_o), W'(0));
    check_val("mid_rst_ready", W'(instr_ready_o), W'(1));
    nrst = 1'b1;
    model_ptr_clear();
    tick();
    read(2, 1'b0);

    load(OP_LA, 0, 8'h00, '1);
    load(OP_LO, 3, 8'hC0, '1);
    send_instr(OP_NOP, 0);
    check_val("nop_done", W'(done_o), W'(0));
    check_val("nop_err", W'(err_o), W'(0));
    send_instr(OP_BAD, 4);
    check_val("bad_err", W'(err_o), W'(1));
    check_val("bad_done", W'(done_o), W'(0));
    check_val("bad_idle", W'(instr_ready_o), W'(1));
    tick();
    check_val("bad_err_sticky", W'(err_o), W'(1));

`ifdef GLOBAL_BUFFER_LANE_MASK_EN
    send_instr(OP_PRST, 0);
    model_ptr_clear();
    tick();
    load(OP_LA, 1, 8'hFF, 16'h0001);
    read(1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
